// File: rtl/fm_move_engine.sv
// fm_move_engine: moves words from the IFM buffer to the OFM buffer.
// Consumes the address sequencer's read/write address streams. Reads are
// issued combinationally. A queue of write addresses realigns each returned
// IFM word with its OFM destination. The move completes once the pipeline
// has fully drained.
module fm_move_engine #(
    parameter int IFM_AW   = 17,
    parameter int OFM_AW   = 17,
    parameter int DATA_W   = 256,
    parameter int RD_LAT   = 2,
    parameter int AQ_DEPTH = 4,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_move_start,
    input  logic              addr_seq_done,
    input  logic              as_rd_vld,
    input  logic [IFM_AW-1:0] as_rd_addr,
    input  logic              as_wr_vld,
    input  logic [OFM_AW-1:0] as_wr_addr,
    output logic              ifm_rd_en,
    output logic [IFM_AW-1:0] ifm_rd_addr,
    input  logic [DATA_W-1:0] ifm_rd_data,
    output logic              ofm_wr_en,
    output logic [OFM_AW-1:0] ofm_wr_addr,
    output logic [DATA_W-1:0] ofm_wr_data,
    output logic              move_busy,
    output logic              move_done,
    output logic              move_err,
    output logic [CNT_W-1:0]  words_moved
);

    localparam int QAW = $clog2(AQ_DEPTH);
    localparam logic [QAW:0] AQ_FULL = (QAW + 1)'(AQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Read-return tracking: one bit per outstanding read cycle.
    logic [RD_LAT-1:0] rd_sr;
    logic              rvld;

    // Write-address queue.
    logic [OFM_AW-1:0] aq_mem [AQ_DEPTH];
    logic [QAW-1:0]    aq_rd_ptr;
    logic [QAW-1:0]    aq_wr_ptr;
    logic [QAW:0]      aq_cnt;
    logic              aq_empty;
    logic              aq_full;

    logic              push;
    logic              bypass;
    logic              q_push;
    logic              q_pop;
    logic              wr_fire;
    logic              overflow;
    logic              underflow;
    logic              stray_rd;
    logic [OFM_AW-1:0] pop_addr;

    assign ifm_rd_en   = as_rd_vld && (state == RUN);
    assign ifm_rd_addr = as_rd_addr;
    assign rvld        = rd_sr[RD_LAT-1];

    assign move_busy = (state != IDLE);
    assign move_done = (state == DONE);

    assign aq_empty = (aq_cnt == '0);
    assign aq_full  = (aq_cnt == AQ_FULL);

    // Write addresses are accepted while a move is active, including the
    // trailing address that arrives one cycle after the last read in DRAIN.
    assign push = as_wr_vld && ((state == RUN) || (state == DRAIN));

    // Empty queue with a simultaneous push and return: use the incoming
    // address directly so it never occupies a slot.
    assign bypass    = push && rvld && aq_empty;
    assign q_pop     = rvld && !aq_empty;
    assign q_push    = push && !bypass && (!aq_full || q_pop);
    assign wr_fire   = q_pop || bypass;
    assign overflow  = push && aq_full && !rvld;
    assign underflow = rvld && aq_empty && !push;
    assign stray_rd  = as_rd_vld && (state != RUN);
    assign pop_addr  = bypass ? as_wr_addr : aq_mem[aq_rd_ptr];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; addr_seq_done takes priority in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (q_move_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (addr_seq_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((rd_sr == '0) && aq_empty && !ofm_wr_en && !push) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Return-tracking shift register: ifm_rd_en delayed by RD_LAT cycles.
    generate
        if (RD_LAT == 1) begin : g_sr1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_sr <= '0;
                end else begin
                    rd_sr <= ifm_rd_en;
                end
            end
        end else begin : g_srn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_sr <= '0;
                end else begin
                    rd_sr <= {rd_sr[RD_LAT-2:0], ifm_rd_en};
                end
            end
        end
    endgenerate

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_rd_ptr <= '0;
            aq_wr_ptr <= '0;
            aq_cnt    <= '0;
        end else begin
            if (q_push) begin
                aq_wr_ptr <= aq_wr_ptr + 1'b1;
            end
            if (q_pop) begin
                aq_rd_ptr <= aq_rd_ptr + 1'b1;
            end
            case ({q_push, q_pop})
                2'b10:   aq_cnt <= aq_cnt + 1'b1;
                2'b01:   aq_cnt <= aq_cnt - 1'b1;
                default: aq_cnt <= aq_cnt;
            endcase
        end
    end

    // Queue storage; contents are meaningful only between the pointers.
    always_ff @(posedge clk) begin
        if (q_push) begin
            aq_mem[aq_wr_ptr] <= as_wr_addr;
        end
    end

    // Registered OFM write port: returned data paired with its popped address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ofm_wr_en   <= 1'b0;
            ofm_wr_addr <= '0;
            ofm_wr_data <= '0;
        end else begin
            ofm_wr_en <= wr_fire;
            if (wr_fire) begin
                ofm_wr_addr <= pop_addr;
                ofm_wr_data <= ifm_rd_data;
            end
        end
    end

    // Word counter: cleared on a new move, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_moved <= '0;
        end else if ((state == IDLE) && q_move_start) begin
            words_moved <= '0;
        end else if (ofm_wr_en && (words_moved != {CNT_W{1'b1}})) begin
            words_moved <= words_moved + 1'b1;
        end
    end

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_err <= 1'b0;
        end else if (stray_rd || overflow || underflow) begin
            move_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fm_move_engine.sv
// Directed testbench for fm_move_engine. Two instances (RD_LAT=2 and RD_LAT=1)
// share one stimulus stream; each has its own IFM buffer model.
module tb_fm_move_engine;

    localparam int IFM_AW = 17;
    localparam int OFM_AW = 17;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 20;
    localparam int OW     = 1 + IFM_AW + 1 + OFM_AW + DATA_W + 3 + CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              q_move_start;
    logic              addr_seq_done;
    logic              as_rd_vld;
    logic [IFM_AW-1:0] as_rd_addr;
    logic              as_wr_vld;
    logic [OFM_AW-1:0] as_wr_addr;

    logic              a_ifm_rd_en, b_ifm_rd_en;
    logic [IFM_AW-1:0] a_ifm_rd_addr, b_ifm_rd_addr;
    logic [DATA_W-1:0] a_ifm_rd_data, b_ifm_rd_data;
    logic              a_ofm_wr_en, b_ofm_wr_en;
    logic [OFM_AW-1:0] a_ofm_wr_addr, b_ofm_wr_addr;
    logic [DATA_W-1:0] a_ofm_wr_data, b_ofm_wr_data;
    logic              a_move_busy, b_move_busy;
    logic              a_move_done, b_move_done;
    logic              a_move_err, b_move_err;
    logic [CNT_W-1:0]  a_words_moved, b_words_moved;

    fm_move_engine #(.IFM_AW(IFM_AW), .OFM_AW(OFM_AW), .DATA_W(DATA_W),
                     .RD_LAT(2), .AQ_DEPTH(4), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .q_move_start(q_move_start), .addr_seq_done(addr_seq_done),
        .as_rd_vld(as_rd_vld), .as_rd_addr(as_rd_addr), .as_wr_vld(as_wr_vld),
        .as_wr_addr(as_wr_addr), .ifm_rd_en(a_ifm_rd_en), .ifm_rd_addr(a_ifm_rd_addr),
        .ifm_rd_data(a_ifm_rd_data), .ofm_wr_en(a_ofm_wr_en), .ofm_wr_addr(a_ofm_wr_addr),
        .ofm_wr_data(a_ofm_wr_data), .move_busy(a_move_busy), .move_done(a_move_done),
        .move_err(a_move_err), .words_moved(a_words_moved)
    );

    fm_move_engine #(.IFM_AW(IFM_AW), .OFM_AW(OFM_AW), .DATA_W(DATA_W),
                     .RD_LAT(1), .AQ_DEPTH(4), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .q_move_start(q_move_start), .addr_seq_done(addr_seq_done),
        .as_rd_vld(as_rd_vld), .as_rd_addr(as_rd_addr), .as_wr_vld(as_wr_vld),
        .as_wr_addr(as_wr_addr), .ifm_rd_en(b_ifm_rd_en), .ifm_rd_addr(b_ifm_rd_addr),
        .ifm_rd_data(b_ifm_rd_data), .ofm_wr_en(b_ofm_wr_en), .ofm_wr_addr(b_ofm_wr_addr),
        .ofm_wr_data(b_ofm_wr_data), .move_busy(b_move_busy), .move_done(b_move_done),
        .move_err(b_move_err), .words_moved(b_words_moved)
    );

    // IFM buffer contents: word at address a is {8{16'hA5A5, a[15:0]}}.
    function automatic logic [DATA_W-1:0] mem_word(input logic [IFM_AW-1:0] a);
        return {8{16'hA5A5, a[15:0]}};
    endfunction

    // IFM buffer models with 2-cycle and 1-cycle read latency.
    logic [IFM_AW-1:0] a_d1, a_d2, b_d1;
    always @(posedge clk) begin
        a_d1 <= a_ifm_rd_addr;
        a_d2 <= a_d1;
        b_d1 <= b_ifm_rd_addr;
    end
    assign a_ifm_rd_data = mem_word(a_d2);
    assign b_ifm_rd_data = mem_word(b_d1);

    logic [OW-1:0] a_outs, b_outs;
    assign a_outs = {a_ifm_rd_en, a_ifm_rd_addr, a_ofm_wr_en, a_ofm_wr_addr, a_ofm_wr_data,
                     a_move_busy, a_move_done, a_move_err, a_words_moved};
    assign b_outs = {b_ifm_rd_en, b_ifm_rd_addr, b_ofm_wr_en, b_ofm_wr_addr, b_ofm_wr_data,
                     b_move_busy, b_move_done, b_move_err, b_words_moved};

    // Cycle counter and write/done monitors, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OFM_AW-1:0] wa_addr[$], wb_addr[$];
    logic [DATA_W-1:0] wa_data[$], wb_data[$];
    int                wa_cyc[$],  wb_cyc[$];
    int done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0, done_cyc_b = 0;

    always @(negedge clk) begin
        if (a_ofm_wr_en === 1'b1) begin
            wa_addr.push_back(a_ofm_wr_addr);
            wa_data.push_back(a_ofm_wr_data);
            wa_cyc.push_back(cyc);
        end
        if (b_ofm_wr_en === 1'b1) begin
            wb_addr.push_back(b_ofm_wr_addr);
            wb_data.push_back(b_ofm_wr_data);
            wb_cyc.push_back(cyc);
        end
        if (a_move_done === 1'b1) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (b_move_done === 1'b1) begin
            done_cnt_b <= done_cnt_b + 1;
            done_cyc_b <= cyc;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        q_move_start  = 1'b0;
        addr_seq_done = 1'b0;
        as_rd_vld     = 1'b0;
        as_rd_addr    = '0;
        as_wr_vld     = 1'b0;
        as_wr_addr    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_run();
        q_move_start = 1'b1;
        tick();
        q_move_start = 1'b0;
    endtask

    task automatic seq_done();
        addr_seq_done = 1'b1;
        tick();
        addr_seq_done = 1'b0;
    endtask

    // Reads base..base+n-1 back to back; write addr 2*a+1 one cycle later.
    task automatic burst(input int n, input int base, input bit with_wr, output int t0);
        t0 = cyc;
        for (int i = 0; i <= n; i++) begin
            as_rd_vld  = (i < n);
            as_rd_addr = IFM_AW'(base + i);
            as_wr_vld  = with_wr && (i >= 1);
            as_wr_addr = OFM_AW'(2 * (base + i - 1) + 1);
            tick();
        end
        clear_inputs();
    endtask

    // Bounded wait for both done pulses beyond the given snapshots.
    task automatic wait_done(input int sa, input int sb, output bit ok);
        int n = 0;
        while ((done_cnt_a == sa || done_cnt_b == sb) && n < 200) begin
            tick();
            n++;
        end
        ok = (done_cnt_a != sa) && (done_cnt_b != sb);
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tests++;
        if (a_outs !== '0) begin
            fails++;
            $display("FAIL reset_outs_a: got %h required 0", a_outs);
        end
        tests++;
        if (b_outs !== '0) begin
            fails++;
            $display("FAIL reset_outs_b: got %h required 0", b_outs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int sa = done_cnt_a, sb = done_cnt_b, na = wa_addr.size(), nb = wb_addr.size();
        int t0;
        bit ok;
        logic [DATA_W-1:0] exp_d = {8{32'hA5A5_0010}};
        start_run();
        t0 = cyc;
        as_rd_vld = 1'b1; as_rd_addr = 17'h10;
        tick();
        as_rd_vld = 1'b0; as_rd_addr = '0;
        as_wr_vld = 1'b1; as_wr_addr = 17'h40;
        tick();
        as_wr_vld = 1'b0; as_wr_addr = '0;
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_done: got timeout required done pulse"); end
        tests++;
        if (wa_addr.size() - na != 1 || wb_addr.size() - nb != 1) begin
            fails++;
            $display("FAIL single_count: got a=%0d b=%0d required 1", wa_addr.size() - na, wb_addr.size() - nb);
        end else begin
            tests++;
            if (wa_addr[na] !== 17'h40 || wb_addr[nb] !== 17'h40) begin
                fails++;
                $display("FAIL single_addr: got a=%h b=%h required 40", wa_addr[na], wb_addr[nb]);
            end
            tests++;
            if (wa_data[na] !== exp_d || wb_data[nb] !== exp_d) begin
                fails++;
                $display("FAIL single_data: got a=%h b=%h required %h", wa_data[na], wb_data[nb], exp_d);
            end
            tests++;
            if (wa_cyc[na] != t0 + 3) begin
                fails++;
                $display("FAIL single_latency_a: got %0d required %0d", wa_cyc[na] - t0, 3);
            end
            tests++;
            if (wb_cyc[nb] != t0 + 2) begin
                fails++;
                $display("FAIL single_latency_b: got %0d required %0d", wb_cyc[nb] - t0, 2);
            end
        end
        tests++;
        if (a_words_moved !== 20'd1 || b_words_moved !== 20'd1) begin
            fails++;
            $display("FAIL single_words: got a=%0d b=%0d required 1", a_words_moved, b_words_moved);
        end
        tests++;
        if (a_move_err !== 1'b0 || b_move_err !== 1'b0) begin
            fails++;
            $display("FAIL single_err: got a=%b b=%b required 0", a_move_err, b_move_err);
        end
        tests++;
        if (done_cnt_a - sa != 1 || done_cnt_b - sb != 1 || a_move_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done_pulse: got a=%0d b=%0d busy=%b required 1 1 0",
                     done_cnt_a - sa, done_cnt_b - sb, a_move_busy);
        end
    endtask

    task automatic test_zero_traffic();
        int sa = done_cnt_a, sb = done_cnt_b, na = wa_addr.size();
        int c;
        bit ok;
        start_run();
        c = cyc;
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok || done_cyc_a - c > 2 || done_cyc_b - c > 2 || done_cyc_a - c < 1) begin
            fails++;
            $display("FAIL zero_done_latency: got a=%0d b=%0d ok=%b required 1..2",
                     done_cyc_a - c, done_cyc_b - c, ok);
        end
        tests++;
        if (a_words_moved !== '0 || b_words_moved !== '0) begin
            fails++;
            $display("FAIL zero_words: got a=%0d b=%0d required 0", a_words_moved, b_words_moved);
        end
        tests++;
        if (wa_addr.size() != na) begin
            fails++;
            $display("FAIL zero_writes: got %0d required 0", wa_addr.size() - na);
        end
    endtask

    task automatic test_back_to_back();
        int sa = done_cnt_a, sb = done_cnt_b, na = wa_addr.size(), nb = wb_addr.size();
        int t0;
        bit ok;
        start_run();
        burst(32, 0, 1'b1, t0);
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL burst_done: got timeout required done pulse"); end
        tests++;
        if (wa_addr.size() - na != 32 || wb_addr.size() - nb != 32) begin
            fails++;
            $display("FAIL burst_count: got a=%0d b=%0d required 32", wa_addr.size() - na, wb_addr.size() - nb);
        end else begin
            for (int i = 0; i < 32; i++) begin
                tests++;
                if (wa_addr[na+i] !== OFM_AW'(2 * i + 1) || wa_data[na+i] !== mem_word(IFM_AW'(i))
                    || wa_cyc[na+i] != t0 + i + 3) begin
                    fails++;
                    $display("FAIL burst_a[%0d]: got addr=%h cyc=%0d required addr=%h cyc=%0d",
                             i, wa_addr[na+i], wa_cyc[na+i] - t0, 2 * i + 1, i + 3);
                end
                tests++;
                if (wb_addr[nb+i] !== OFM_AW'(2 * i + 1) || wb_data[nb+i] !== mem_word(IFM_AW'(i))
                    || wb_cyc[nb+i] != t0 + i + 2) begin
                    fails++;
                    $display("FAIL burst_b[%0d]: got addr=%h cyc=%0d required addr=%h cyc=%0d",
                             i, wb_addr[nb+i], wb_cyc[nb+i] - t0, 2 * i + 1, i + 2);
                end
            end
        end
        tests++;
        if (a_words_moved !== 20'd32 || b_words_moved !== 20'd32) begin
            fails++;
            $display("FAIL burst_words: got a=%0d b=%0d required 32", a_words_moved, b_words_moved);
        end
        tests++;
        if (a_move_err !== 1'b0 || b_move_err !== 1'b0) begin
            fails++;
            $display("FAIL burst_err: got a=%b b=%b required 0", a_move_err, b_move_err);
        end
    endtask

    task automatic test_overflow();
        int sa, sb, na, nb;
        bit ok;
        do_reset();
        sa = done_cnt_a; sb = done_cnt_b; na = wa_addr.size(); nb = wb_addr.size();
        start_run();
        for (int i = 0; i < 5; i++) begin
            as_wr_vld  = 1'b1;
            as_wr_addr = OFM_AW'(17'h100 + i);
            tick();
        end
        clear_inputs();
        tick();
        tests++;
        if (a_move_err !== 1'b1 || b_move_err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_err: got a=%b b=%b required 1", a_move_err, b_move_err);
        end
        tests++;
        if (wa_addr.size() != na || wb_addr.size() != nb) begin
            fails++;
            $display("FAIL ovf_no_write: got a=%0d b=%0d required 0", wa_addr.size() - na, wb_addr.size() - nb);
        end
        for (int i = 0; i < 4; i++) begin
            as_rd_vld  = 1'b1;
            as_rd_addr = IFM_AW'(i);
            tick();
        end
        clear_inputs();
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL ovf_done: got timeout required done pulse"); end
        tests++;
        if (wa_addr.size() - na != 4 || wb_addr.size() - nb != 4) begin
            fails++;
            $display("FAIL ovf_count: got a=%0d b=%0d required 4", wa_addr.size() - na, wb_addr.size() - nb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wa_addr[na+i] !== OFM_AW'(17'h100 + i) || wb_addr[nb+i] !== OFM_AW'(17'h100 + i)
                    || wa_data[na+i] !== mem_word(IFM_AW'(i)) || wb_data[nb+i] !== mem_word(IFM_AW'(i))) begin
                    fails++;
                    $display("FAIL ovf_word[%0d]: got a=%h b=%h required %h",
                             i, wa_addr[na+i], wb_addr[nb+i], 17'h100 + i);
                end
            end
        end
        tests++;
        if (a_move_err !== 1'b1 || b_move_err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_err_sticky: got a=%b b=%b required 1", a_move_err, b_move_err);
        end
        do_reset();
        tests++;
        if (a_move_err !== 1'b0 || b_move_err !== 1'b0) begin
            fails++;
            $display("FAIL ovf_err_cleared: got a=%b b=%b required 0", a_move_err, b_move_err);
        end
    endtask

    task automatic test_underflow();
        int sa, sb, na, nb;
        bit ok;
        do_reset();
        sa = done_cnt_a; sb = done_cnt_b; na = wa_addr.size(); nb = wb_addr.size();
        start_run();
        as_rd_vld = 1'b1; as_rd_addr = 17'h5;
        tick();
        clear_inputs();
        tick();
        tick();
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL unf_done: got timeout required done pulse"); end
        tests++;
        if (wa_addr.size() != na || wb_addr.size() != nb) begin
            fails++;
            $display("FAIL unf_no_write: got a=%0d b=%0d required 0", wa_addr.size() - na, wb_addr.size() - nb);
        end
        tests++;
        if (a_move_err !== 1'b1 || b_move_err !== 1'b1) begin
            fails++;
            $display("FAIL unf_err: got a=%b b=%b required 1", a_move_err, b_move_err);
        end
        tests++;
        if (a_words_moved !== '0 || b_words_moved !== '0) begin
            fails++;
            $display("FAIL unf_words: got a=%0d b=%0d required 0", a_words_moved, b_words_moved);
        end
    endtask

    task automatic test_idle_read();
        do_reset();
        as_rd_vld = 1'b1; as_rd_addr = 17'h33;
        #1;
        tests++;
        if (a_ifm_rd_en !== 1'b0 || b_ifm_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL idle_rd_en: got a=%b b=%b required 0", a_ifm_rd_en, b_ifm_rd_en);
        end
        tick();
        clear_inputs();
        tests++;
        if (a_move_err !== 1'b1 || b_move_err !== 1'b1) begin
            fails++;
            $display("FAIL idle_rd_err: got a=%b b=%b required 1", a_move_err, b_move_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int sa, sb, na, nb, t0;
        bit ok;
        do_reset();
        start_run();
        for (int i = 0; i < 3; i++) begin
            as_rd_vld  = 1'b1;
            as_rd_addr = IFM_AW'(i);
            as_wr_vld  = (i >= 1);
            as_wr_addr = OFM_AW'(2 * (i - 1) + 1);
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        tests++;
        if (a_outs !== '0 || b_outs !== '0) begin
            fails++;
            $display("FAIL midrst_outs: got a=%h b=%h required 0", a_outs, b_outs);
        end
        na = wa_addr.size(); nb = wb_addr.size();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        tests++;
        if (wa_addr.size() != na || wb_addr.size() != nb) begin
            fails++;
            $display("FAIL midrst_no_write: got a=%0d b=%0d required 0", wa_addr.size() - na, wb_addr.size() - nb);
        end
        sa = done_cnt_a; sb = done_cnt_b;
        start_run();
        burst(8, 32, 1'b1, t0);
        seq_done();
        wait_done(sa, sb, ok);
        tests++;
        if (!ok || wa_addr.size() - na != 8 || wb_addr.size() - nb != 8) begin
            fails++;
            $display("FAIL midrst_restart_count: got a=%0d b=%0d ok=%b required 8",
                     wa_addr.size() - na, wb_addr.size() - nb, ok);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (wa_addr[na+i] !== OFM_AW'(2 * (32 + i) + 1) || wb_addr[nb+i] !== OFM_AW'(2 * (32 + i) + 1)
                    || wa_data[na+i] !== mem_word(IFM_AW'(32 + i)) || wb_data[nb+i] !== mem_word(IFM_AW'(32 + i))) begin
                    fails++;
                    $display("FAIL midrst_word[%0d]: got a=%h b=%h required %h",
                             i, wa_addr[na+i], wb_addr[nb+i], 2 * (32 + i) + 1);
                end
            end
        end
        tests++;
        if (a_words_moved !== 20'd8 || b_words_moved !== 20'd8 || a_move_err !== 1'b0 || b_move_err !== 1'b0) begin
            fails++;
            $display("FAIL midrst_words: got a=%0d b=%0d err=%b%b required 8 8 00",
                     a_words_moved, b_words_moved, a_move_err, b_move_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_single();
        test_zero_traffic();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_idle_read();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
